layer_sequencer: RTL and testbench

//   Frame-level scheduler for the CNN inference chain (conv2d -> relu -> maxpool -> dense).

---
 rtl/layer_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_layer_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// layer_sequencer
//   Frame-level scheduler for the CNN inference chain (conv2d -> relu -> maxpool -> dense).
//   Each layer engine is launched in order with a one-cycle start pulse. The sequencer
//   then waits for that engine's done pulse. Every wait is guarded by a watchdog. The
//   sequencer reports either frame completion or the stage that hung. It holds no
//   feature data.
//
// Parameters
//   NUM_STAGES      number of sequenced engines, stage 0 launched first (>= 1)
//   TIMEOUT_CYCLES  max WAIT cycles per stage before error; 0 disables the watchdog
//   CW              width of watchdog and perf counters
//
// Ports
//   i_clk           single clock, rising edge
//   i_reset         synchronous, active-high; wins over every other input
//   i_start         frame request, sampled only in IDLE
//   i_abort         cancel the frame in progress (LAUNCH/WAIT only)
//   i_clear         leave ERROR
//   o_stage_start   one-hot start pulse to engine i
//   i_stage_done    done pulse from engine i
//   o_cur_stage     index of the active stage
//   o_busy          high in LAUNCH, WAIT and FINISH
//   o_done          one-cycle frame-complete pulse
//   o_error         sticky watchdog error flag
//   o_err_stage     stage that timed out
//   o_frame_cycles  LAUNCH+WAIT cycles of the last completed frame
//
// Build option
//   SEQ_PERF_COUNT_EN  when defined, builds the frame cycle counter behind
//                      o_frame_cycles. When undefined, o_frame_cycles is tied to 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for i_start
// LAUNCH | one-cycle start pulse to engine r_cur_stage, watchdog loaded
// WAIT   | waiting for done of r_cur_stage, watchdog counting down
// FINISH | one-cycle frame done pulse
// ERROR  | watchdog expired; hold error/err_stage until i_clear

module layer_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int CW             = 32,
    localparam int SW            = $clog2(NUM_STAGES) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic                  i_clear,
    output logic [NUM_STAGES-1:0] o_stage_start,
    input  logic [NUM_STAGES-1:0] i_stage_done,
    output logic [SW-1:0]         o_cur_stage,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [SW-1:0]         o_err_stage,
    output logic [CW-1:0]         o_frame_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FINISH,
        S_ERROR
    } state_t;

    localparam bit          WDG_EN   = (TIMEOUT_CYCLES != 0);
    // Down-counter load value. Terminal count 0 is reached on the last allowed WAIT cycle.
    localparam logic [CW-1:0] WDG_LOAD = WDG_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    state_t          r_state;
    state_t          w_next;
    logic [SW-1:0]   r_cur_stage;
    logic [CW-1:0]   r_wcnt;
    logic            r_error;
    logic [SW-1:0]   r_err_stage;
    logic            w_done_cur;
    logic            w_last;

    // Select the done bit of the active stage. Other stages' done bits are ignored.
    always_comb begin
        w_done_cur = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (r_cur_stage == SW'(i)) begin
                w_done_cur = i_stage_done[i];
            end
        end
    end

    assign w_last = (r_cur_stage == SW'(NUM_STAGES - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_next = i_abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (i_abort) begin
                    w_next = S_IDLE;
                end else if (w_done_cur) begin
                    w_next = w_last ? S_FINISH : S_LAUNCH;
                end else if (WDG_EN && (r_wcnt == '0)) begin
                    w_next = S_ERROR;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            S_ERROR: begin
                if (i_clear) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cur_stage <= '0;
            r_wcnt      <= '0;
            r_error     <= 1'b0;
            r_err_stage <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cur_stage <= '0;
                    end
                end
                S_LAUNCH: begin
                    r_wcnt <= WDG_LOAD;
                end
                S_WAIT: begin
                    if (!i_abort) begin
                        if (w_done_cur) begin
                            if (!w_last) begin
                                r_cur_stage <= r_cur_stage + 1'b1;
                            end
                        end else if (WDG_EN && (r_wcnt == '0)) begin
                            r_error     <= 1'b1;
                            r_err_stage <= r_cur_stage;
                        end else if (r_wcnt != '0) begin
                            r_wcnt <= r_wcnt - 1'b1;
                        end
                    end
                end
                S_ERROR: begin
                    if (i_clear) begin
                        r_error     <= 1'b0;
                        r_err_stage <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        o_stage_start = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            o_stage_start[i] = (r_state == S_LAUNCH) && (r_cur_stage == SW'(i));
        end
    end

    assign o_cur_stage = r_cur_stage;
    assign o_busy      = (r_state == S_LAUNCH) || (r_state == S_WAIT) || (r_state == S_FINISH);
    assign o_done      = (r_state == S_FINISH);
    assign o_error     = r_error;
    assign o_err_stage = r_err_stage;

`ifdef SEQ_PERF_COUNT_EN
    logic [CW-1:0] r_pcnt;
    logic [CW-1:0] r_frame_cycles;
    logic [CW-1:0] w_pcnt_inc;

    assign w_pcnt_inc = (r_pcnt == '1) ? r_pcnt : r_pcnt + 1'b1;

    // The latch on entry to FINISH uses the incremented value.
    // This way the last WAIT cycle is included in the count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pcnt         <= '0;
            r_frame_cycles <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_pcnt <= '0;
            end else if ((r_state == S_LAUNCH) || (r_state == S_WAIT)) begin
                r_pcnt <= w_pcnt_inc;
            end
            if ((r_state == S_WAIT) && (w_next == S_FINISH)) begin
                r_frame_cycles <= w_pcnt_inc;
            end
        end
    end

    assign o_frame_cycles = r_frame_cycles;
`else
    assign o_frame_cycles = '0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;

    localparam int NS = 4;
    localparam int TO = 16;
    localparam int CW = 32;
    localparam int SW = $clog2(NS) + 1;
`ifdef SEQ_PERF_COUNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int K_START = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort_r = 1'b0;
    logic          clear = 1'b0;
    logic [NS-1:0] sdone = '0;
    logic [NS-1:0] sstart;
    logic [SW-1:0] cur_stage;
    logic          busy;
    logic          done;
    logic          error;
    logic [SW-1:0] err_stage;
    logic [CW-1:0] frame_cycles;

    layer_sequencer #(
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (TO),
        .CW             (CW)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_abort        (abort_r),
        .i_clear        (clear),
        .o_stage_start  (sstart),
        .i_stage_done   (sdone),
        .o_cur_stage    (cur_stage),
        .o_busy         (busy),
        .o_done         (done),
        .o_error        (error),
        .o_err_stage    (err_stage),
        .o_frame_cycles (frame_cycles)
    );

    always #5 clk = ~clk;

    int n_cyc = 0;
    always @(posedge clk) n_cyc <= n_cyc + 1;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    function automatic logic [31:0] fc(int v);
        return PERF ? 32'(v) : 32'd0;
    endfunction

    function automatic void expect_ev(int kind, int cyc, logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.cyc  = cyc;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    task automatic check_ev(int kind, logic [31:0] data);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind=%0d cyc=%0d data=%0h, required no event",
                     kind, n_cyc, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != n_cyc || e.data != data) begin
                n_fail++;
                $display("FAIL event: got kind=%0d cyc=%0d data=%0h, required kind=%0d cyc=%0d data=%0h",
                         kind, n_cyc, data, e.kind, e.cyc, e.data);
            end
        end
    endtask

    // Monitor: every observable DUT event is matched against the scoreboard queue.
    logic prev_err = 1'b0;
    always @(negedge clk) begin
        if (sstart != '0) check_ev(K_START, 32'(sstart));
        if (done) check_ev(K_DONE, frame_cycles);
        if (error && !prev_err) check_ev(K_ERR, 32'(err_stage));
        prev_err = error;
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(int c);
        while (n_cyc < c) step();
    endtask

    task automatic pulse_done(int s, int c);
        goto(c);
        sdone    = '0;
        sdone[s] = 1'b1;
        step();
        sdone = '0;
    endtask

    task automatic launch(output int t);
        t     = n_cyc + 1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of stimulus, required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t;
        // reset, with start asserted underneath it
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_stage_start", 32'(sstart), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_err_stage", 32'(err_stage), 0);
        chk("rst_cur_stage", 32'(cur_stage), 0);
        chk("rst_frame_cycles", frame_cycles, 0);
        step();

        // T1: every done 3 cycles after its start pulse
        launch(t);
        for (int i = 0; i < NS; i++) expect_ev(K_START, t + 4 * i, 32'(1) << i);
        expect_ev(K_DONE, t + 16, fc(16));
        for (int i = 0; i < NS; i++) begin
            pulse_done(i, t + 4 * i + 3);
            chk("t1_busy", 32'(busy), 1);
            chk("t1_cur_stage", 32'(cur_stage), (i < NS - 1) ? 32'(i + 1) : 32'(NS - 1));
        end
        goto(t + 17);
        chk("t1_error", 32'(error), 0);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_cur_hold", 32'(cur_stage), 3);
        step();

        // T2: done on the first WAIT cycle of every stage
        launch(t);
        for (int i = 0; i < NS; i++) expect_ev(K_START, t + 2 * i, 32'(1) << i);
        expect_ev(K_DONE, t + 8, fc(8));
        for (int i = 0; i < NS; i++) pulse_done(i, t + 2 * i + 1);
        goto(t + 9);
        chk("t2_frame_cycles", frame_cycles, fc(8));
        step();

        // T3: stage 1 hangs; watchdog fires after 16 WAIT cycles
        launch(t);
        expect_ev(K_START, t, 32'h1);
        expect_ev(K_START, t + 2, 32'h2);
        expect_ev(K_ERR, t + 19, 32'd1);
        pulse_done(0, t + 1);
        goto(t + 18);
        chk("t3_no_error_yet", 32'(error), 0);
        chk("t3_busy_wait", 32'(busy), 1);
        goto(t + 19);
        chk("t3_error", 32'(error), 1);
        chk("t3_err_stage", 32'(err_stage), 1);
        chk("t3_busy_err", 32'(busy), 0);
        start = 1'b1;
        repeat (2) step();
        start   = 1'b0;
        abort_r = 1'b1;
        step();
        abort_r = 1'b0;
        chk("t3_error_held", 32'(error), 1);
        chk("t3_busy_held", 32'(busy), 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t3_clear_error", 32'(error), 0);
        chk("t3_clear_err_stage", 32'(err_stage), 0);
        step();

        // T4: wrong done bit while waiting on stage 0
        launch(t);
        expect_ev(K_START, t, 32'h1);
        expect_ev(K_START, t + 5, 32'h2);
        expect_ev(K_START, t + 7, 32'h4);
        expect_ev(K_START, t + 9, 32'h8);
        expect_ev(K_DONE, t + 11, fc(11));
        pulse_done(2, t + 2);
        chk("t4_still_stage0", 32'(cur_stage), 0);
        pulse_done(0, t + 4);
        pulse_done(1, t + 6);
        pulse_done(2, t + 8);
        pulse_done(3, t + 10);
        goto(t + 12);

        // T5: abort in WAIT of stage 2, then abort in LAUNCH, then a fresh frame
        launch(t);
        expect_ev(K_START, t, 32'h1);
        expect_ev(K_START, t + 2, 32'h2);
        expect_ev(K_START, t + 4, 32'h4);
        pulse_done(0, t + 1);
        pulse_done(1, t + 3);
        goto(t + 6);
        abort_r = 1'b1;
        step();
        abort_r = 1'b0;
        chk("t5_abort_busy", 32'(busy), 0);
        pulse_done(2, t + 8);
        goto(t + 12);
        chk("t5_frame_cycles_kept", frame_cycles, fc(11));
        launch(t);
        expect_ev(K_START, t, 32'h1);
        abort_r = 1'b1;
        step();
        abort_r = 1'b0;
        chk("t5_launch_abort_busy", 32'(busy), 0);
        step();
        launch(t);
        for (int i = 0; i < NS; i++) expect_ev(K_START, t + 2 * i, 32'(1) << i);
        expect_ev(K_DONE, t + 8, fc(8));
        for (int i = 0; i < NS; i++) pulse_done(i, t + 2 * i + 1);
        goto(t + 10);

        // T7: done arrives on the last allowed WAIT cycle -> done wins
        launch(t);
        expect_ev(K_START, t, 32'h1);
        expect_ev(K_START, t + 17, 32'h2);
        expect_ev(K_START, t + 19, 32'h4);
        expect_ev(K_START, t + 21, 32'h8);
        expect_ev(K_DONE, t + 23, fc(23));
        pulse_done(0, t + 16);
        pulse_done(1, t + 18);
        pulse_done(2, t + 20);
        pulse_done(3, t + 22);
        goto(t + 24);
        chk("t7_no_error", 32'(error), 0);
        step();

        // T6: start held high across a frame, then reset mid-WAIT
        t     = n_cyc + 1;
        start = 1'b1;
        for (int i = 0; i < NS; i++) expect_ev(K_START, t + 2 * i, 32'(1) << i);
        expect_ev(K_DONE, t + 8, fc(8));
        expect_ev(K_START, t + 10, 32'h1);
        step();
        for (int i = 0; i < NS; i++) pulse_done(i, t + 2 * i + 1);
        goto(t + 11);
        start = 1'b0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_stage_start", 32'(sstart), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_error", 32'(error), 0);
        chk("t6_err_stage", 32'(err_stage), 0);
        chk("t6_cur_stage", 32'(cur_stage), 0);
        chk("t6_frame_cycles", frame_cycles, 0);
        repeat (10) step();

        chk("pending_events", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
